// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: opcodes, FSM states and
// the bit positions inside the {V,C,N,Z} flag vector.
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int FLAG_W = 4;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_ASR = 4'd7,
    ALU_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// BUS steps after start_i. product_o carries the final sum in the done cycle.
module alu_iter_mul #(
  parameter int BUS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BUS-1:0]   a_i,
  input  logic [BUS-1:0]   b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2*BUS-1:0] product_o
);

  localparam int CW = $clog2(BUS);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [2*BUS-1:0] r_acc;
  logic [2*BUS-1:0] r_mcand;
  logic [BUS-1:0]   r_mplier;

  logic [2*BUS-1:0] w_step;
  logic [2*BUS-1:0] w_acc_next;

  assign w_step     = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_step;

  // The last step's sum is exposed directly so the owner can register it in
  // the same edge the multiplier goes idle.
  assign busy_o    = r_busy;
  assign done_o    = r_busy & (r_cnt == CW'(BUS-1));
  assign product_o = w_acc_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start_i) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{BUS{1'b0}}, a_i};
      r_mplier <= b_i;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (done_o) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// Registered ALU with valid/ready on both sides; single-cycle ops return in
// one cycle, MUL runs through the iterative multiplier for BUS cycles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The source holds valid and its payload until then; ready never depends
// on valid; valid_o and the result stay fixed in HOLD until ready_i is seen.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int BUS = 8,
  parameter int SHW = $clog2(BUS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [BUS-1:0]    A_i,
  input  logic [BUS-1:0]    B_i,
  input  logic [OP_W-1:0]   ALU_op_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [BUS-1:0]    ALU_RESULT_o,
  output logic [FLAG_W-1:0] ALU_FLAGS_o
);

  alu_state_e        r_state;
  logic              r_valid;
  logic [BUS-1:0]    r_result;
  logic [FLAG_W-1:0] r_flags;

  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [2*BUS-1:0]  w_mul_prod;
  logic              w_mul_hi;
  logic [FLAG_W-1:0] w_mul_flg;

  logic [SHW-1:0]    w_amt;
  logic [BUS-1:0]    w_res;
  logic              w_c;
  logic              w_v;
  logic [FLAG_W-1:0] w_flg;

  assign ready_o     = (r_state == IDLE) | ((r_state == HOLD) & ready_i);
  assign w_accept    = valid_i & ready_o;
  assign w_is_mul    = (ALU_op_i == ALU_MUL);
  assign w_mul_start = w_accept & w_is_mul;

  assign valid_o      = r_valid;
  assign ALU_RESULT_o = r_result;
  assign ALU_FLAGS_o  = r_flags;

  alu_iter_mul #(.BUS(BUS)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (w_mul_start),
    .a_i       (A_i),
    .b_i       (B_i),
    .busy_o    (w_mul_busy),
    .done_o    (w_mul_done),
    .product_o (w_mul_prod)
  );

  // Shifts run on a widened operand so the extra bit catches the last bit
  // shifted out; a zero amount leaves that bit clear.
  always_comb begin
    w_amt = B_i[SHW-1:0];
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALU_op_i)
      ALU_ADD: begin
        {w_c, w_res} = {1'b0, A_i} + {1'b0, B_i};
        w_v = (A_i[BUS-1] == B_i[BUS-1]) && (w_res[BUS-1] != A_i[BUS-1]);
      end
      ALU_SUB: begin
        {w_c, w_res} = {1'b0, A_i} + {1'b0, ~B_i} + {{BUS{1'b0}}, 1'b1};
        w_v = (A_i[BUS-1] != B_i[BUS-1]) && (w_res[BUS-1] != A_i[BUS-1]);
      end
      ALU_AND: w_res = A_i & B_i;
      ALU_OR:  w_res = A_i | B_i;
      ALU_XOR: w_res = A_i ^ B_i;
      ALU_SHL: {w_c, w_res} = {1'b0, A_i} << w_amt;
      ALU_SHR: {w_res, w_c} = {A_i, 1'b0} >> w_amt;
      ALU_ASR: {w_res, w_c} = $signed({A_i, 1'b0}) >>> w_amt;
      default: w_res = '0;
    endcase
    w_flg        = '0;
    w_flg[FLG_V] = w_v;
    w_flg[FLG_C] = w_c;
    w_flg[FLG_N] = w_res[BUS-1];
    w_flg[FLG_Z] = (w_res == '0);
  end

  always_comb begin
    w_mul_hi         = |w_mul_prod[2*BUS-1:BUS];
    w_mul_flg        = '0;
    w_mul_flg[FLG_V] = w_mul_hi;
    w_mul_flg[FLG_C] = w_mul_hi;
    w_mul_flg[FLG_N] = w_mul_prod[BUS-1];
    w_mul_flg[FLG_Z] = (w_mul_prod[BUS-1:0] == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= BUSY;
              r_valid <= 1'b0;
            end else begin
              r_state  <= HOLD;
              r_valid  <= 1'b1;
              r_result <= w_res;
              r_flags  <= w_flg;
            end
          end else if ((r_state == HOLD) && ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (w_mul_done) begin
            r_state  <= HOLD;
            r_valid  <= 1'b1;
            r_result <= w_mul_prod[BUS-1:0];
            r_flags  <= w_mul_flg;
          end else if (!w_mul_busy) begin
            // Multiplier idle without a done pulse: recover rather than hang.
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
